// File: rtl/cache_pkg.sv
// Shared types and address-split helpers for the set-associative cache.
package cache_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StCompare,
      StWriteback,
      StRefill,
      StRespond
   } cache_state_e;

   function automatic int unsigned offset_bits(int unsigned line_words);
      return $clog2(line_words);
   endfunction

   function automatic int unsigned index_bits(int unsigned num_sets);
      return $clog2(num_sets);
   endfunction

   function automatic int unsigned tag_bits(int unsigned word_size, int unsigned num_sets,
                                            int unsigned line_words);
      return word_size - offset_bits(line_words) - index_bits(num_sets);
   endfunction

endpackage

// File: rtl/cache_lru.sv
// True-LRU age tracker: one age per way per set, age NUM_WAYS-1 is the victim.
module cache_lru
   import cache_pkg::*;
#(
   parameter int unsigned NUM_WAYS = 2,
   parameter int unsigned NUM_SETS = 2,
   localparam int unsigned WayW = $clog2(NUM_WAYS),
   localparam int unsigned SetW = index_bits(NUM_SETS)
) (
   input  logic            clk_i,
   input  logic            reset_i,
   input  logic [SetW-1:0] set_i,
   input  logic [WayW-1:0] way_i,
   input  logic            upd_i,
   output logic [WayW-1:0] victim_o
);

   logic [WayW-1:0] age_q [NUM_SETS][NUM_WAYS];
   logic [WayW-1:0] age_d [NUM_WAYS];

   // Accessed way becomes youngest; only ways younger than it age by one.
   always_comb begin
      for (int w = 0; w < NUM_WAYS; w++) begin
         age_d[w] = age_q[set_i][w];
         if (WayW'(w) == way_i) begin
            age_d[w] = '0;
         end else if (age_q[set_i][w] < age_q[set_i][way_i]) begin
            age_d[w] = age_q[set_i][w] + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         for (int s = 0; s < NUM_SETS; s++) begin
            for (int w = 0; w < NUM_WAYS; w++) begin
               age_q[s][w] <= WayW'(w);
            end
         end
      end else if (upd_i) begin
         for (int w = 0; w < NUM_WAYS; w++) begin
            age_q[set_i][w] <= age_d[w];
         end
      end
   end

   always_comb begin
      victim_o = '0;
      for (int w = 0; w < NUM_WAYS; w++) begin
         if (age_q[set_i][w] == WayW'(NUM_WAYS - 1)) victim_o = WayW'(w);
      end
   end

endmodule

// File: rtl/cache_sa_wb.sv
// N-way set-associative write-back, write-allocate data cache with true-LRU replacement.
// Define CACHE_STATS_EN to add saturating 16-bit hit/miss counters.
module cache_sa_wb
   import cache_pkg::*;
#(
   parameter int unsigned WORD_SIZE  = 16,
   parameter int unsigned NUM_WAYS   = 2,
   parameter int unsigned NUM_SETS   = 2,
   parameter int unsigned LINE_WORDS = 4
) (
   input  logic                            clk_i,
   input  logic                            reset_i,
   input  logic                            cpu_req_valid_i,
   input  logic                            cpu_req_write_i,
   input  logic [WORD_SIZE-1:0]            cpu_req_addr_i,
   input  logic [WORD_SIZE-1:0]            cpu_req_wdata_i,
   output logic                            cpu_req_ready_o,
   output logic                            cpu_resp_valid_o,
   output logic [WORD_SIZE-1:0]            cpu_resp_rdata_o,
   output logic                            mem_rd_req_o,
   output logic [WORD_SIZE-1:0]            mem_rd_addr_o,
   input  logic                            mem_rd_ack_i,
   input  logic [WORD_SIZE*LINE_WORDS-1:0] mem_rd_data_i,
   output logic                            mem_wr_req_o,
   output logic [WORD_SIZE-1:0]            mem_wr_addr_o,
   output logic [WORD_SIZE*LINE_WORDS-1:0] mem_wr_data_o,
   input  logic                            mem_wr_ack_i
`ifdef CACHE_STATS_EN
   ,
   output logic [15:0]                     stat_hits_o,
   output logic [15:0]                     stat_misses_o
`endif
);

   localparam int unsigned OffW = offset_bits(LINE_WORDS);
   localparam int unsigned IdxW = index_bits(NUM_SETS);
   localparam int unsigned TagW = tag_bits(WORD_SIZE, NUM_SETS, LINE_WORDS);
   localparam int unsigned WayW = $clog2(NUM_WAYS);

   cache_state_e state_q, state_d;

   logic                 req_write_q;
   logic [WORD_SIZE-1:0] req_addr_q, req_wdata_q, rdata_q;
   logic [WayW-1:0]      victim_q;

   logic [TagW-1:0]      tag_q   [NUM_WAYS][NUM_SETS];
   logic                 valid_q [NUM_WAYS][NUM_SETS];
   logic                 dirty_q [NUM_WAYS][NUM_SETS];
   logic [WORD_SIZE-1:0] data_q  [NUM_WAYS][NUM_SETS][LINE_WORDS];

   logic [OffW-1:0] req_off;
   logic [IdxW-1:0] req_idx;
   logic [TagW-1:0] req_tag;
   logic            hit, inv_found, victim_dirty, lru_upd;
   logic [WayW-1:0] hit_way, inv_way, lru_victim, victim_sel, lru_way;

   assign req_off = req_addr_q[OffW-1:0];
   assign req_idx = req_addr_q[OffW +: IdxW];
   assign req_tag = req_addr_q[WORD_SIZE-1 -: TagW];

   always_comb begin
      hit       = 1'b0;
      hit_way   = '0;
      inv_found = 1'b0;
      inv_way   = '0;
      for (int w = 0; w < NUM_WAYS; w++) begin
         if (valid_q[w][req_idx] && tag_q[w][req_idx] == req_tag) begin
            hit     = 1'b1;
            hit_way = WayW'(w);
         end
      end
      // Descending scan so the lowest-index invalid way is the one kept.
      for (int w = NUM_WAYS - 1; w >= 0; w--) begin
         if (!valid_q[w][req_idx]) begin
            inv_found = 1'b1;
            inv_way   = WayW'(w);
         end
      end
   end

   assign victim_sel   = inv_found ? inv_way : lru_victim;
   assign victim_dirty = valid_q[victim_sel][req_idx] && dirty_q[victim_sel][req_idx];
   assign lru_upd      = (state_q == StCompare && hit) || (state_q == StRefill && mem_rd_ack_i);
   assign lru_way      = (state_q == StRefill) ? victim_q : hit_way;

   cache_lru #(
      .NUM_WAYS (NUM_WAYS),
      .NUM_SETS (NUM_SETS)
   ) u_lru (
      .clk_i    (clk_i),
      .reset_i  (reset_i),
      .set_i    (req_idx),
      .way_i    (lru_way),
      .upd_i    (lru_upd),
      .victim_o (lru_victim)
   );

   always_ff @(posedge clk_i) begin
      if (reset_i) state_q <= StIdle;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle:      if (cpu_req_valid_i) state_d = StCompare;
         StCompare: begin
            if (hit)               state_d = StRespond;
            else if (victim_dirty) state_d = StWriteback;
            else                   state_d = StRefill;
         end
         StWriteback: if (mem_wr_ack_i) state_d = StRefill;
         StRefill:    if (mem_rd_ack_i) state_d = StCompare;
         StRespond:   state_d = StIdle;
         default:     state_d = StIdle;
      endcase
   end

   always_comb begin
      cpu_req_ready_o  = 1'b0;
      cpu_resp_valid_o = 1'b0;
      cpu_resp_rdata_o = '0;
      mem_rd_req_o     = 1'b0;
      mem_rd_addr_o    = '0;
      mem_wr_req_o     = 1'b0;
      mem_wr_addr_o    = '0;
      mem_wr_data_o    = '0;
      case (state_q)
         StIdle: cpu_req_ready_o = !reset_i;
         StWriteback: begin
            mem_wr_req_o  = 1'b1;
            mem_wr_addr_o = {tag_q[victim_q][req_idx], req_idx, {OffW{1'b0}}};
            for (int i = 0; i < LINE_WORDS; i++) begin
               mem_wr_data_o[(LINE_WORDS-1-i)*WORD_SIZE +: WORD_SIZE] = data_q[victim_q][req_idx][i];
            end
         end
         StRefill: begin
            mem_rd_req_o  = 1'b1;
            mem_rd_addr_o = {req_tag, req_idx, {OffW{1'b0}}};
         end
         StRespond: begin
            cpu_resp_valid_o = 1'b1;
            cpu_resp_rdata_o = rdata_q;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         req_write_q <= 1'b0;
         req_addr_q  <= '0;
         req_wdata_q <= '0;
         rdata_q     <= '0;
         victim_q    <= '0;
         for (int w = 0; w < NUM_WAYS; w++) begin
            for (int s = 0; s < NUM_SETS; s++) begin
               valid_q[w][s] <= 1'b0;
               dirty_q[w][s] <= 1'b0;
            end
         end
      end else begin
         if (state_q == StIdle && cpu_req_valid_i) begin
            req_write_q <= cpu_req_write_i;
            req_addr_q  <= cpu_req_addr_i;
            req_wdata_q <= cpu_req_wdata_i;
         end
         if (state_q == StCompare) begin
            if (hit && req_write_q)  dirty_q[hit_way][req_idx] <= 1'b1;
            else if (hit)            rdata_q <= data_q[hit_way][req_idx][req_off];
            else                     victim_q <= victim_sel;
         end
         if (state_q == StRefill && mem_rd_ack_i) begin
            valid_q[victim_q][req_idx] <= 1'b1;
            dirty_q[victim_q][req_idx] <= 1'b0;
         end
      end
   end

   // Tags and line data are qualified by valid bits and need no reset.
   always_ff @(posedge clk_i) begin
      if (state_q == StCompare && hit && req_write_q) begin
         data_q[hit_way][req_idx][req_off] <= req_wdata_q;
      end
      if (state_q == StRefill && mem_rd_ack_i) begin
         tag_q[victim_q][req_idx] <= req_tag;
         for (int i = 0; i < LINE_WORDS; i++) begin
            data_q[victim_q][req_idx][i] <= mem_rd_data_i[(LINE_WORDS-1-i)*WORD_SIZE +: WORD_SIZE];
         end
      end
   end

`ifdef CACHE_STATS_EN
   logic        retry_q;
   logic [15:0] hits_q, misses_q;

   // The lookup following a refill is a retry and is not counted.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         retry_q  <= 1'b0;
         hits_q   <= '0;
         misses_q <= '0;
      end else begin
         if (state_q == StRefill && mem_rd_ack_i) retry_q <= 1'b1;
         else if (state_q == StCompare)           retry_q <= 1'b0;
         if (state_q == StCompare && !retry_q) begin
            if (hit && hits_q != 16'hFFFF)         hits_q   <= hits_q + 16'd1;
            else if (!hit && misses_q != 16'hFFFF) misses_q <= misses_q + 16'd1;
         end
      end
   end

   assign stat_hits_o   = hits_q;
   assign stat_misses_o = misses_q;
`endif

endmodule

// File: tb/tb_cache_sa_wb.sv
// Scoreboard bench for cache_sa_wb: an abstract per-set LRU-list model predicts responses and
// memory traffic; a CPU-side monitor and a memory responder compare against it.
module tb_cache_sa_wb;

   localparam int WAYS = 2;
   localparam int SETS = 2;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        cpu_req_valid = 1'b0;
   logic        cpu_req_write = 1'b0;
   logic [15:0] cpu_req_addr = '0;
   logic [15:0] cpu_req_wdata = '0;
   logic        cpu_req_ready, cpu_resp_valid;
   logic [15:0] cpu_resp_rdata;
   logic        mem_rd_req, mem_wr_req;
   logic [15:0] mem_rd_addr, mem_wr_addr;
   logic [63:0] mem_wr_data;
   logic        mem_rd_ack = 1'b0;
   logic        mem_wr_ack = 1'b0;
   logic [63:0] mem_rd_data = '0;
`ifdef CACHE_STATS_EN
   logic [15:0] stat_hits, stat_misses;
`endif

   always #5 clk = ~clk;

   cache_sa_wb dut (
      .clk_i            (clk),
      .reset_i          (reset),
      .cpu_req_valid_i  (cpu_req_valid),
      .cpu_req_write_i  (cpu_req_write),
      .cpu_req_addr_i   (cpu_req_addr),
      .cpu_req_wdata_i  (cpu_req_wdata),
      .cpu_req_ready_o  (cpu_req_ready),
      .cpu_resp_valid_o (cpu_resp_valid),
      .cpu_resp_rdata_o (cpu_resp_rdata),
      .mem_rd_req_o     (mem_rd_req),
      .mem_rd_addr_o    (mem_rd_addr),
      .mem_rd_ack_i     (mem_rd_ack),
      .mem_rd_data_i    (mem_rd_data),
      .mem_wr_req_o     (mem_wr_req),
      .mem_wr_addr_o    (mem_wr_addr),
      .mem_wr_data_o    (mem_wr_data),
      .mem_wr_ack_i     (mem_wr_ack)
`ifdef CACHE_STATS_EN
      ,
      .stat_hits_o      (stat_hits),
      .stat_misses_o    (stat_misses)
`endif
   );

   typedef struct packed {logic [12:0] tag; logic dirty; logic [63:0] line;} ent_t;
   typedef struct packed {logic is_read; logic [15:0] data;} resp_t;
   typedef struct packed {logic [15:0] addr; logic [63:0] data;} wr_t;

   ent_t        sets_q [SETS][$];
   resp_t       exp_resp_q [$];
   wr_t         exp_wr_q [$];
   logic [15:0] exp_rd_q [$];
   logic [15:0] ref_mem [256];
   logic [15:0] bmem [256];

   int checks = 0;
   int failures = 0;
   int rd_delay = 0;
   int wr_delay = 0;
   logic ack_with_reset = 1'b0;

   task automatic check(input string name, input logic [79:0] act, input logic [79:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Abstract cache: each set is an MRU-first list of resident lines.
   task automatic model_access(input logic wr, input logic [15:0] addr, input logic [15:0] wdata,
                               output logic hit, output logic [15:0] rdata);
      int   idx, o, pos, base;
      ent_t e, v;
      idx  = int'(addr[2]);
      o    = int'(addr[1:0]);
      base = int'(addr[7:0]) & 252;
      pos  = -1;
      for (int i = 0; i < sets_q[idx].size(); i++) begin
         if (sets_q[idx][i].tag == addr[15:3]) pos = i;
      end
      hit = (pos >= 0);
      if (hit) begin
         e = sets_q[idx][pos];
         sets_q[idx].delete(pos);
      end else begin
         if (sets_q[idx].size() == WAYS) begin
            v = sets_q[idx].pop_back();
            if (v.dirty) begin
               exp_wr_q.push_back('{addr: {v.tag, addr[2], 2'b00}, data: v.line});
               for (int i = 0; i < 4; i++) ref_mem[(int'({v.tag[4:0], addr[2], 2'b00}) + i) & 255]
                  = v.line[(3-i)*16 +: 16];
            end
         end
         exp_rd_q.push_back({addr[15:2], 2'b00});
         e.tag   = addr[15:3];
         e.dirty = 1'b0;
         e.line  = {ref_mem[base], ref_mem[base+1], ref_mem[base+2], ref_mem[base+3]};
      end
      rdata = e.line[(3-o)*16 +: 16];
      if (wr) begin
         e.line[(3-o)*16 +: 16] = wdata;
         e.dirty = 1'b1;
      end
      sets_q[idx].push_front(e);
   endtask

   task automatic model_reset();
      for (int s = 0; s < SETS; s++) sets_q[s].delete();
      exp_resp_q.delete();
      exp_wr_q.delete();
      exp_rd_q.delete();
   endtask

   task automatic do_reset(input int cycles);
      @(negedge clk);
      reset = 1'b1;
      repeat (cycles) @(negedge clk);
      reset = 1'b0;
      model_reset();
   endtask

   task automatic issue(input logic wr, input logic [15:0] addr, input logic [15:0] wdata,
                        input logic wait_done);
      logic        hit;
      logic [15:0] rd;
      int          n, lat;
      n = 0;
      while (!cpu_req_ready && n < 500) begin
         @(negedge clk);
         n++;
      end
      if (!cpu_req_ready) begin
         check("ready_timeout", cpu_req_ready, 1);
         return;
      end
      model_access(wr, addr, wdata, hit, rd);
      exp_resp_q.push_back('{is_read: !wr, data: rd});
      cpu_req_valid = 1'b1;
      cpu_req_write = wr;
      cpu_req_addr  = addr;
      cpu_req_wdata = wdata;
      @(posedge clk);
      @(negedge clk);
      cpu_req_valid = 1'b0;
      if (wait_done) begin
         lat = 1;
         while (!cpu_resp_valid && lat < 500) begin
            @(negedge clk);
            lat++;
         end
         if (!cpu_resp_valid) check("resp_timeout", cpu_resp_valid, 1);
         else if (hit)        check("hit_latency", 80'(lat), 80'd2);
         else                 check("miss_latency", lat > 2, 1);
      end
   endtask

   // CPU-side monitor.
   resp_t mon_r;
   always @(negedge clk) begin
      if (!reset && cpu_resp_valid) begin
         if (exp_resp_q.size() == 0) begin
            check("unexpected_resp", 80'(exp_resp_q.size()), 80'd1);
         end else begin
            mon_r = exp_resp_q.pop_front();
            if (mon_r.is_read) check("rdata", cpu_resp_rdata, mon_r.data);
         end
      end
   end

   // Memory responder and memory-side monitor.
   initial begin
      int          cnt, b;
      logic [15:0] hold_addr;
      logic [63:0] hold_data;
      wr_t         ew;
      logic [15:0] er;
      cnt = 0;
      forever begin
         @(negedge clk);
         mem_rd_ack = 1'b0;
         mem_wr_ack = 1'b0;
         if (ack_with_reset) begin
            ack_with_reset = 1'b0;
            mem_rd_ack     = 1'b1;
            mem_rd_data    = 64'hDEAD_BEEF_CAFE_F00D;
            cnt            = 0;
         end else if (reset) begin
            cnt = 0;
         end else if (mem_wr_req) begin
            check("req_exclusive", mem_rd_req, 0);
            if (cnt == 0) begin
               hold_addr = mem_wr_addr;
               hold_data = mem_wr_data;
            end else begin
               check("wr_addr_stable", mem_wr_addr, hold_addr);
               check("wr_data_stable", mem_wr_data, hold_data);
            end
            if (cnt >= wr_delay) begin
               mem_wr_ack = 1'b1;
               cnt        = 0;
               if (exp_wr_q.size() == 0) begin
                  check("unexpected_wr", 80'(exp_wr_q.size()), 80'd1);
               end else begin
                  ew = exp_wr_q.pop_front();
                  check("wr_addr", mem_wr_addr, ew.addr);
                  check("wr_data", mem_wr_data, ew.data);
               end
               b = int'(mem_wr_addr[7:0]);
               for (int i = 0; i < 4; i++) bmem[(b + i) & 255] = mem_wr_data[(3-i)*16 +: 16];
            end else begin
               cnt++;
            end
         end else if (mem_rd_req) begin
            if (cnt == 0) hold_addr = mem_rd_addr;
            else          check("rd_addr_stable", mem_rd_addr, hold_addr);
            if (cnt >= rd_delay) begin
               mem_rd_ack = 1'b1;
               cnt        = 0;
               b          = int'(mem_rd_addr[7:0]);
               for (int i = 0; i < 4; i++) mem_rd_data[(3-i)*16 +: 16] = bmem[(b + i) & 255];
               if (exp_rd_q.size() == 0) begin
                  check("unexpected_rd", 80'(exp_rd_q.size()), 80'd1);
               end else begin
                  er = exp_rd_q.pop_front();
                  check("rd_addr", mem_rd_addr, er);
               end
            end else begin
               cnt++;
            end
         end else begin
            cnt = 0;
         end
      end
   end

   initial begin
      #900000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n;
      for (int i = 0; i < 256; i++) begin
         ref_mem[i] = 16'($urandom);
         bmem[i]    = ref_mem[i];
      end
      ref_mem[16] = 16'hA000; ref_mem[17] = 16'hB000; ref_mem[18] = 16'hC000; ref_mem[19] = 16'hD000;
      for (int i = 16; i < 20; i++) bmem[i] = ref_mem[i];

      @(negedge clk);
      check("rst_ready", cpu_req_ready, 0);
      check("rst_resp_valid", cpu_resp_valid, 0);
      check("rst_rdata", cpu_resp_rdata, 0);
      check("rst_mem_req", {mem_rd_req, mem_wr_req}, 0);
      check("rst_mem_addr", {mem_rd_addr, mem_wr_addr}, 0);
      check("rst_wr_data", mem_wr_data, 0);
      reset = 1'b0;
      #1;
      check("ready_after_rst", cpu_req_ready, 1);

      // Cold miss, hit in same line, write hit, read-back.
      issue(0, 16'h0010, 0, 1);
      issue(0, 16'h0012, 0, 1);
      issue(1, 16'h0011, 16'hBEEF, 1);
      issue(0, 16'h0011, 0, 1);

      // Dirty eviction of 0x0000 with a slow write-back ack.
      wr_delay = 3;
      issue(0, 16'h0000, 0, 1);
      issue(0, 16'h0008, 0, 1);
      issue(1, 16'h0001, 16'h1234, 1);
      issue(0, 16'h0008, 0, 1);
      issue(0, 16'h0010, 0, 1);

      // Clean eviction, refill ack withheld 5 cycles.
      do_reset(1);
      rd_delay = 5;
      issue(0, 16'h0000, 0, 1);
      issue(0, 16'h0008, 0, 1);
      issue(0, 16'h0008, 0, 1);
      issue(0, 16'h0010, 0, 1);

      // Reset arriving together with the refill ack.
      do_reset(1);
      rd_delay = 1000;
      issue(0, 16'h0020, 0, 0);
      n = 0;
      while (!mem_rd_req && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("refill_seen", mem_rd_req, 1);
      #1;
      ack_with_reset = 1'b1;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      model_reset();
      #1;
      check("rst_mid_rd_req", mem_rd_req, 0);
      check("rst_mid_ready", cpu_req_ready, 1);
      rd_delay = 1;
      issue(0, 16'h0020, 0, 1);

`ifdef CACHE_STATS_EN
      do_reset(1);
      issue(0, 16'h0000, 0, 1);
      issue(0, 16'h0008, 0, 1);
      issue(0, 16'h0000, 0, 1);
      issue(0, 16'h0010, 0, 1);
      issue(0, 16'h0010, 0, 1);
      check("stat_misses", stat_misses, 3);
      check("stat_hits", stat_hits, 2);
      do_reset(1);
      check("stat_clear", {stat_hits, stat_misses}, 0);
`endif

      // Random traffic over a small address window to force conflicts.
      do_reset(1);
      for (int k = 0; k < 300; k++) begin
         rd_delay = int'($urandom_range(0, 3));
         wr_delay = int'($urandom_range(0, 3));
         issue(1'($urandom_range(0, 1)), 16'($urandom_range(0, 63)), 16'($urandom), 1);
      end

      @(negedge clk);
      check("resp_drained", 80'(exp_resp_q.size()), 80'd0);
      check("rd_drained", 80'(exp_rd_q.size()), 80'd0);
      check("wr_drained", 80'(exp_wr_q.size()), 80'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
